multiplier_register: RTL and testbench
======================================

Name: multiplier_register

Overview:
- Bit-serial multiplier store and sequencer; the stage that consumes the serial multiplicand stream `mcand` from the multiplicand block.
- Loads a WORD_BITS multiplier word serially, then steps through it one minor cycle per multiplier bit, LSB first.
- Each minor cycle it gates the multiplicand stream into the accumulator adder as a serial addend.
- The final (sign) bit is issued as a subtract, giving two's-complement products.

Parameters:
- WORD_BITS, 17, multiplier word length in digits; the MSB is the sign.
- MINOR_CYCLE, 18, digit periods per minor cycle (WORD_BITS plus gap digits); must be > WORD_BITS.

Ports:
- clk  input  1  digit clock.
- rst  input  1  asynchronous reset, active-high.
- c1  input  1  minor-cycle start pulse, one clk wide, from the timing chain.
- mlt_in  input  1  serial multiplier data, LSB first, valid on digits 0..WORD_BITS-1.
- load  input  1  request to load the multiplier during the next minor cycle.
- start  input  1  request to begin multiplication at the next c1.
- mcand  input  1  serial multiplicand bit from the multiplicand block.
- addend  output  1  serial addend to the accumulator: mcand gated by the current multiplier bit.
- sub  output  1  high for the whole sign-bit minor cycle; the accumulator subtracts.
- busy  output  1  high in LOAD or MULT.
- done  output  1  one-clk pulse after the last multiplier step.
- step  output  5  index of the multiplier bit being applied (0..WORD_BITS-1).

Behaviour:
- Reset values (async, immediate): addend=0, sub=0, busy=0, done=0, step=0. Shift register cleared, digit counter=0, state=IDLE.
- Digit counter: forced to 0 on c1, otherwise increments each clk and saturates at MINOR_CYCLE-1.
- A c1 that arrives early resynchronises the counter; this is not an error.
- States:
  - IDLE: on c1 with load=1, go to LOAD. Else on c1 with start=1, go to MULT with step=0. load has priority if both are high.
  - LOAD: on digits 0..WORD_BITS-1, shift mlt_in into the register MSB end (right shift). After digit WORD_BITS-1, go to IDLE; the register then holds the word with bit0 = LSB. busy=1 throughout.
  - MULT: cur_bit = reg[0], latched at c1.
    - On digits 0..WORD_BITS-1: addend = mcand & cur_bit, combinational from mcand through one AND. Zero latency, so the accumulator sees it in the same digit.
    - On gap digits: addend=0.
    - sub=1 for the whole minor cycle when step==WORD_BITS-1.
    - At the next c1: reg shifts right one (zero fill) and step increments.
    - At the c1 ending step WORD_BITS-1: go to DONE.
  - DONE: done=1 for exactly one clk, then IDLE. busy=0 in DONE.
- load or start while busy: ignored, not queued.
- start with no prior load: multiplies by the current register contents (0 after reset).
- c1 never arrives: the block holds its state indefinitely; no timeout.
- Reset mid-LOAD or mid-MULT: abort immediately; all state returns to reset values.
- Width rule: step is 5 bits. WORD_BITS ≤ 31 is required; elaboration error otherwise.

Optional Feature:
- MULT_EARLY_EXIT_EN defined:
  - At each MULT c1, if the remaining register bits (including sign) are all zero, go directly to DONE.
  - Saves the remaining minor cycles.
  - done still pulses once; step freezes at the exit value.
- Undefined: always exactly WORD_BITS minor cycles in MULT.

Decomposition:
- Shared package edsac_timing_pkg holds:
  - WORD_BITS_SHORT=17, MINOR_CYCLE_DIGITS=18.
  - State enum typedef mreg_state_t {IDLE, LOAD, MULT, DONE}.
  - Digit-counter width constant.
- One natural sub-module: digit_counter (c1-synchronised saturating counter). It is reusable by the multiplicand and accumulator stages.
- The shift register and FSM stay in the top module.

Test Plan:
- Load 17'h00005 with a c1+load pulse, then c1+start, with mcand serial 17'h00003 each minor cycle.
  - addend is nonzero only in steps 0 and 2, each equal to the 3-stream.
  - sub=0 in all steps; done pulses once after the 17th c1.
- Load 17'h10000 (sign only), start.
  - addend=0 for steps 0..15.
  - Step 16: addend = mcand stream and sub=1 for that minor cycle.
- Assert load and start on the same c1.
  - LOAD is entered, start is dropped.
  - busy rises, and the register equals the serial word after digit 16.
- Assert rst at step 7 of MULT.
  - addend, sub, busy, step go to 0 asynchronously in the same clk.
  - The next c1+start multiplies by 0: addend stays 0 for all steps.
- Send c1 pulses 12 digits apart instead of 18 during MULT.
  - The counter resyncs, and addend stays gated to digits <12.
  - Step still advances once per c1.
- With MULT_EARLY_EXIT_EN, load 17'h00001 and start.
  - done pulses at the c1 ending step 0, and step freezes at 1.
  - Without the macro, done pulses after step 16.

Source files
------------

// File: rtl/edsac_timing_pkg.sv
// Shared timing constants and state encoding for the serial arithmetic stages.
package edsac_timing_pkg;

  localparam int WORD_BITS_SHORT    = 17;
  localparam int MINOR_CYCLE_DIGITS = 18;
  localparam int DIGIT_CNT_W        = $clog2(MINOR_CYCLE_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MULT,
    DONE
  } mreg_state_t;

endpackage

// File: rtl/digit_counter.sv
// Digit-within-minor-cycle counter. A c1 pulse restarts the count at 0 on the
// following digit; without c1 it counts up and parks on the last digit.
module digit_counter
  import edsac_timing_pkg::*;
#(
  parameter int MINOR_CYCLE = MINOR_CYCLE_DIGITS,
  parameter int CNT_W       = DIGIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c1,
  output logic [CNT_W-1:0] digit
);

  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(MINOR_CYCLE - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Resynchronise on every c1, early or not; saturate if c1 goes missing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (c1) begin
      cnt_reg <= '0;
    end else if (cnt_reg != LAST_DIGIT) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign digit = cnt_reg;

endmodule

// File: rtl/multiplier_register.sv
// Bit-serial multiplier store and sequencer. Loads the multiplier word serially,
// then applies one multiplier bit per minor cycle (LSB first) as a gate on the
// multiplicand stream; the sign-bit minor cycle is flagged as a subtract.
// Optional build macro: MULT_EARLY_EXIT_EN - finish as soon as the multiplier
// bits still to be applied are all zero.
module multiplier_register
  import edsac_timing_pkg::*;
#(
  parameter int WORD_BITS   = WORD_BITS_SHORT,
  parameter int MINOR_CYCLE = MINOR_CYCLE_DIGITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c1,
  input  logic       mlt_in,
  input  logic       load,
  input  logic       start,
  input  logic       mcand,
  output logic       addend,
  output logic       sub,
  output logic       busy,
  output logic       done,
  output logic [4:0] step
);

  localparam int                CNT_W           = DIGIT_CNT_W;
  localparam logic [CNT_W-1:0]  LAST_DATA_DIGIT = CNT_W'(WORD_BITS - 1);
  localparam logic [4:0]        LAST_STEP       = 5'(WORD_BITS - 1);

  // Parameter sanity: step is 5 bits wide and the gap digit(s) must exist.
  generate
    if (WORD_BITS > 31 || WORD_BITS < 2) begin : g_word_bits_check
      $error("multiplier_register: WORD_BITS must be in 2..31");
    end
    if (MINOR_CYCLE <= WORD_BITS) begin : g_minor_cycle_check
      $error("multiplier_register: MINOR_CYCLE must exceed WORD_BITS");
    end
    if (MINOR_CYCLE > (1 << CNT_W)) begin : g_cnt_width_check
      $error("multiplier_register: MINOR_CYCLE does not fit the digit counter");
    end
  endgenerate

  mreg_state_t          state_reg, state_next;
  logic [WORD_BITS-1:0] shift_reg, shift_next;
  logic [4:0]           step_reg, step_next;
  logic                 cur_bit_reg, cur_bit_next;
  logic [CNT_W-1:0]     digit;
  logic                 in_data;
  logic [WORD_BITS-2:0] upper_bits;

  digit_counter #(
    .MINOR_CYCLE (MINOR_CYCLE),
    .CNT_W       (CNT_W)
  ) u_digit_counter (
    .clk   (clk),
    .rst   (rst),
    .c1    (c1),
    .digit (digit)
  );

  // Data digits carry word bits; the remaining digits of a minor cycle are gap.
  assign in_data = (digit <= LAST_DATA_DIGIT);

  // Bits above the LSB, used by both the load shift and the multiply shift.
  for (genvar gi = 0; gi < WORD_BITS - 1; gi++) begin : g_upper
    assign upper_bits[gi] = shift_reg[gi+1];
  end

  // State, multiplier store, step index and the latched multiplier bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      step_reg    <= '0;
      cur_bit_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      step_reg    <= step_next;
      cur_bit_reg <= cur_bit_next;
    end
  end

  // Next-state logic: requests are only honoured from IDLE, on c1.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    step_next    = step_reg;
    cur_bit_next = cur_bit_reg;
    case (state_reg)
      IDLE: begin
        if (c1) begin
          if (load) begin
            state_next = LOAD;
          end else if (start) begin
            state_next   = MULT;
            step_next    = '0;
            cur_bit_next = shift_reg[0];
          end
        end
      end
      LOAD: begin
        // Serial word enters at the MSB end so bit0 ends up as the LSB.
        if (in_data) begin
          shift_next = {mlt_in, upper_bits};
          if (digit == LAST_DATA_DIGIT) begin
            state_next = IDLE;
          end
        end
      end
      MULT: begin
        if (c1) begin
          if (step_reg == LAST_STEP) begin
            state_next = DONE;
          end else begin
            shift_next   = {1'b0, upper_bits};
            step_next    = step_reg + 5'd1;
            cur_bit_next = upper_bits[0];
`ifdef MULT_EARLY_EXIT_EN
            if (upper_bits == '0) begin
              state_next = DONE;
            end
`endif
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The addend path is a single AND so the accumulator sees it in-digit.
  assign addend = mcand & cur_bit_reg & in_data & (state_reg == MULT);
  assign sub    = (state_reg == MULT) & (step_reg == LAST_STEP);
  assign busy   = (state_reg == LOAD) | (state_reg == MULT);
  assign done   = (state_reg == DONE);
  assign step   = step_reg;

endmodule

// File: tb/tb_multiplier_register.sv
// Self-checking bench for multiplier_register: a behavioural model tracks the
// loaded word, the digit position and the multiplier step; a compare process
// checks every output on every negedge, and directed scenarios pin totals.
module tb_multiplier_register;

  localparam int WB = 17;
  localparam int MC = 18;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       c1 = 1'b0;
  logic       mlt_in = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       mcand = 1'b0;
  logic       addend, sub, busy, done;
  logic [4:0] step;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  int addend_ones = 0;
  int sub_cycles  = 0;
  int done_pulses = 0;
  int done_step   = -1;

  typedef enum {M_IDLE, M_LOAD, M_MULT, M_DONE} mmode_t;
  mmode_t        m_mode  = M_IDLE;
  int            m_digit = 0;
  int            m_step  = 0;
  logic [WB-1:0] m_word  = '0;

  logic [WB-1:0] w_tmp;

  multiplier_register dut (
    .clk    (clk),
    .rst    (rst),
    .c1     (c1),
    .mlt_in (mlt_in),
    .load   (load),
    .start  (start),
    .mcand  (mcand),
    .addend (addend),
    .sub    (sub),
    .busy   (busy),
    .done   (done),
    .step   (step)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WB-1:0] rnd();
    return 17'($urandom);
  endfunction

  // Behavioural model: the word as an integer, the multiplier bit selected by
  // the step index, the digit as clocks since the last c1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= M_IDLE;
      m_digit <= 0;
      m_step  <= 0;
      m_word  <= '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (c1) begin
            if (load) begin
              m_mode <= M_LOAD;
            end else if (start) begin
              m_mode <= M_MULT;
              m_step <= 0;
            end
          end
        end
        M_LOAD: begin
          if (m_digit < WB) begin
            m_word[m_digit] <= mlt_in;
            if (m_digit == WB - 1) m_mode <= M_IDLE;
          end
        end
        M_MULT: begin
          if (c1) begin
            if (m_step == WB - 1) begin
              m_mode <= M_DONE;
            end else begin
              m_step <= m_step + 1;
`ifdef MULT_EARLY_EXIT_EN
              if ((m_word >> (m_step + 1)) == 0) m_mode <= M_DONE;
`endif
            end
          end
        end
        M_DONE: m_mode <= M_IDLE;
        default: m_mode <= M_IDLE;
      endcase
      m_digit <= c1 ? 0 : ((m_digit < MC - 1) ? m_digit + 1 : m_digit);
    end
  end

  // Compare process plus observation counters.
  always @(negedge clk) begin
    if (checking) begin
      chk("addend", int'(addend),
          (m_mode == M_MULT && m_digit < WB && m_word[m_step] && mcand) ? 1 : 0);
      chk("sub", int'(sub), (m_mode == M_MULT && m_step == WB - 1) ? 1 : 0);
      chk("busy", int'(busy), (m_mode == M_LOAD || m_mode == M_MULT) ? 1 : 0);
      chk("done", int'(done), (m_mode == M_DONE) ? 1 : 0);
      chk("step", int'(step), m_step);
      if (addend) addend_ones <= addend_ones + 1;
      if (sub) sub_cycles <= sub_cycles + 1;
      if (done) begin
        done_pulses <= done_pulses + 1;
        done_step   <= int'(step);
      end
    end
  end

  // One minor cycle of len digits; c1 (with the given load/start) on the last.
  task automatic cycle_minor(int len, bit ld, bit st, logic [WB-1:0] mw, logic [WB-1:0] mc);
    for (int d = 0; d < len; d++) begin
      mlt_in = (d < WB) ? mw[d] : 1'($urandom);
      mcand  = (d < WB) ? mc[d] : 1'($urandom);
      c1     = (d == len - 1);
      load   = (d == len - 1) ? ld : 1'($urandom);
      start  = (d == len - 1) ? st : 1'($urandom);
      @(posedge clk);
      #1;
    end
    c1 = 1'b0;
  endtask

  task automatic load_seq(logic [WB-1:0] w, bit also_start);
    cycle_minor(MC, 1'b1, also_start, rnd(), rnd());
    chk("load_busy", int'(busy), 1);
    cycle_minor(MC, 1'b0, 1'b0, w, rnd());
    chk("load_model_word", int'(m_word), int'(w));
    chk("load_back_idle", int'(busy), 0);
  endtask

  task automatic mult_seq(logic [WB-1:0] mc, int len, bit stray);
    addend_ones = 0;
    sub_cycles  = 0;
    done_pulses = 0;
    done_step   = -1;
    cycle_minor(MC, 1'b0, 1'b1, rnd(), rnd());
    chk("mult_busy", int'(busy), 1);
    for (int s = 0; s < WB; s++) begin
      cycle_minor(len, (stray && s < WB - 1) ? 1'($urandom) : 1'b0,
                  (stray && s < WB - 1) ? 1'($urandom) : 1'b0, rnd(), mc);
    end
    cycle_minor(MC, 1'b0, 1'b0, rnd(), rnd());
    chk("done_pulses", done_pulses, 1);
  endtask

  initial begin
    #3 rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
    end
    #1;
    chk("reset_addend", int'(addend), 0);
    chk("reset_sub", int'(sub), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_step", int'(step), 0);
    rst = 1'b0;
    checking = 1'b1;

    // Multiplier 5 times multiplicand 3: bits 0 and 2 pass the 3-stream.
    load_seq(17'h00005, 1'b0);
    mult_seq(17'h00003, MC, 1'b0);
    chk("t1_addend_ones", addend_ones, 4);
`ifdef MULT_EARLY_EXIT_EN
    chk("t1_sub_cycles", sub_cycles, 0);
    chk("t1_done_step", done_step, 3);
`else
    chk("t1_sub_cycles", sub_cycles, 18);
    chk("t1_done_step", done_step, 16);
`endif

    // Sign bit only: one subtract minor cycle carrying the multiplicand.
    load_seq(17'h10000, 1'b0);
    mult_seq(17'h0000B, MC, 1'b1);
    chk("t2_addend_ones", addend_ones, 3);
    chk("t2_sub_cycles", sub_cycles, 18);
    chk("t2_done_step", done_step, 16);

    // load and start together: load wins, start is dropped.
    w_tmp = rnd() | 17'h10000;
    load_seq(w_tmp, 1'b1);
    mult_seq(rnd(), MC, 1'b1);

    // Asynchronous reset in the middle of step 7.
    load_seq(17'h1FFFF, 1'b0);
    cycle_minor(MC, 1'b0, 1'b1, rnd(), rnd());
    for (int s = 0; s < 7; s++) cycle_minor(MC, 1'b0, 1'b0, rnd(), 17'h1FFFF);
    c1 = 1'b0; load = 1'b0; start = 1'b0; mcand = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t4_step_before", int'(step), 7);
    chk("t4_addend_before", int'(addend), 1);
    chk("t4_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_addend_rst", int'(addend), 0);
    chk("t4_sub_rst", int'(sub), 0);
    chk("t4_busy_rst", int'(busy), 0);
    chk("t4_step_rst", int'(step), 0);
    chk("t4_done_rst", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mult_seq(17'h1FFFF, MC, 1'b0);
    chk("t4_addend_ones_after_rst", addend_ones, 0);

    // c1 every 12 digits: only digits 0..11 ever carry the addend.
    load_seq(17'h1FFFF, 1'b0);
    mult_seq(17'h1FFFF, 12, 1'b1);
    chk("t5_addend_ones", addend_ones, 204);
    chk("t5_sub_cycles", sub_cycles, 12);
    chk("t5_done_step", done_step, 16);

    // Multiplier 1: early exit after step 0 when enabled.
    load_seq(17'h00001, 1'b0);
    mult_seq(17'h00003, MC, 1'b0);
    chk("t6_addend_ones", addend_ones, 2);
`ifdef MULT_EARLY_EXIT_EN
    chk("t6_done_step", done_step, 1);
`else
    chk("t6_done_step", done_step, 16);
`endif

    // Randomised words and multiplicands against the model.
    for (int i = 0; i < 6; i++) begin
      w_tmp = rnd();
      load_seq(w_tmp, 1'b0);
      mult_seq(rnd(), MC, w_tmp[WB-1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
